// File: rtl/ws2812b_rx.sv
// ws2812b_rx: WS2812B NRZ pulse-stream decoder producing 24-bit GRB pixel words,
// per-frame pixel index, latch (frame_done) detection and error pulses.
// Optional build macro WS2812B_RX_PASSTHRU_EN: act as one chained LED, forwarding
// every bit after the first pixel of each frame on dout.
module ws2812b_rx #(
  parameter int unsigned HIGH_THRESH  = 8,
  parameter int unsigned MIN_HIGH     = 2,
  parameter int unsigned MAX_HIGH     = 14,
  parameter int unsigned RESET_CYCLES = 600,
  parameter int unsigned IDX_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  output logic [23:0]      pixel_data,
  output logic             pixel_valid,
  output logic [IDX_W-1:0] pixel_index,
  output logic             frame_done,
  output logic             rx_error,
  output logic             dout
);

  localparam int unsigned CNT_W = $clog2(RESET_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W-1:0] LATCH_AT  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] HI_MAX    = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] HI_MIN    = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] HI_THRESH = CNT_W'(HIGH_THRESH);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_e;

  state_e             state_q, state_d;
  logic               meta_q, din_s_q, din_d1_q;
  logic [CNT_W-1:0]   hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0]   lo_cnt_q, lo_cnt_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic [22:0]        shift_q, shift_d;
  logic [23:0]        pixel_data_q, pixel_data_d;
  logic               pixel_valid_q, pixel_valid_d;
  logic [IDX_W-1:0]   pixel_index_q, pixel_index_d;
  logic               frame_done_q, frame_done_d;
  logic               rx_error_q, rx_error_d;
  logic               rise, fall, bit_val;

  assign rise    = din_s_q & ~din_d1_q;
  assign fall    = ~din_s_q & din_d1_q;
  assign bit_val = (hi_cnt_q >= HI_THRESH);

  // Input synchronizer plus edge-detect flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= 1'b0;
      din_s_q  <= 1'b0;
      din_d1_q <= 1'b0;
    end else begin
      meta_q   <= din;
      din_s_q  <= meta_q;
      din_d1_q <= din_s_q;
    end
  end

  // Decoder state, counters and registered output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SYNC;
      hi_cnt_q      <= '0;
      lo_cnt_q      <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
      pixel_index_q <= '0;
      frame_done_q  <= 1'b0;
      rx_error_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hi_cnt_q      <= hi_cnt_d;
      lo_cnt_q      <= lo_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      pixel_data_q  <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_index_q <= pixel_index_d;
      frame_done_q  <= frame_done_d;
      rx_error_q    <= rx_error_d;
    end
  end

  // Next-state logic: pulse-width measurement, bit decode and latch detection.
  always_comb begin
    state_d       = state_q;
    hi_cnt_d      = hi_cnt_q;
    lo_cnt_d      = lo_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    pixel_data_d  = pixel_data_q;
    pixel_valid_d = 1'b0;
    frame_done_d  = 1'b0;
    rx_error_d    = 1'b0;
    pixel_index_d = pixel_index_q;
    if (pixel_valid_q && (pixel_index_q != {IDX_W{1'b1}})) begin
      pixel_index_d = pixel_index_q + 1'b1;
    end
    case (state_q)
      SYNC: begin
        if (din_s_q) begin
          lo_cnt_d = '0;
        end else if (lo_cnt_q == LATCH_AT) begin
          state_d = IDLE;
        end else if (lo_cnt_q != CNT_SAT) begin
          lo_cnt_d = lo_cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (rise) begin
          state_d  = HIGH;
          hi_cnt_d = CNT_W'(1);
        end
      end
      HIGH: begin
        if ((hi_cnt_q == HI_MAX) || (fall && (hi_cnt_q < HI_MIN))) begin
          rx_error_d = 1'b1;
          state_d    = SYNC;
          lo_cnt_d   = '0;
          bit_cnt_d  = '0;
        end else if (fall) begin
          shift_d  = {shift_q[21:0], bit_val};
          state_d  = LOW;
          lo_cnt_d = CNT_W'(1);
          if (bit_cnt_q == 5'd23) begin
            pixel_data_d  = {shift_q, bit_val};
            pixel_valid_d = 1'b1;
            bit_cnt_d     = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (hi_cnt_q != CNT_SAT) begin
          hi_cnt_d = hi_cnt_q + 1'b1;
        end
      end
      LOW: begin
        if (rise) begin
          state_d  = HIGH;
          hi_cnt_d = CNT_W'(1);
        end else if (!din_s_q) begin
          if (lo_cnt_q == LATCH_AT) begin
            frame_done_d  = 1'b1;
            pixel_index_d = '0;
            state_d       = IDLE;
            rx_error_d    = (bit_cnt_q != '0);
            bit_cnt_d     = '0;
          end else if (lo_cnt_q != CNT_SAT) begin
            lo_cnt_d = lo_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  assign pixel_data  = pixel_data_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_index = pixel_index_q;
  assign frame_done  = frame_done_q;
  assign rx_error    = rx_error_q;

`ifdef WS2812B_RX_PASSTHRU_EN
  logic pass_active_q, pass_active_d;
  logic dout_q;

  // Forwarding enable: opens after this LED's own pixel, closes on latch or error.
  always_comb begin
    pass_active_d = pass_active_q;
    if (frame_done_q || rx_error_q) begin
      pass_active_d = 1'b0;
    end else if (pixel_valid_q && (pixel_index_q == '0)) begin
      pass_active_d = 1'b1;
    end
  end

  // Registered chain output, three clocks behind din.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_active_q <= 1'b0;
      dout_q        <= 1'b0;
    end else begin
      pass_active_q <= pass_active_d;
      dout_q        <= din_s_q & pass_active_q;
    end
  end

  assign dout = dout_q;
`else
  assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812b_rx.sv
module tb_ws2812b_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [7:0]  pixel_index;
  logic        frame_done;
  logic        rx_error;
  logic        dout;

  ws2812b_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .pixel_data (pixel_data),
    .pixel_valid(pixel_valid),
    .pixel_index(pixel_index),
    .frame_done (frame_done),
    .rx_error   (rx_error),
    .dout       (dout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder sampled on the falling edge.
  logic [23:0] vdata [0:63];
  logic [7:0]  vidx  [0:63];
  int nvalid = 0, nfd = 0, nerr = 0, nboth = 0, ndout = 0;
  int unsigned ecyc = 0;
  logic din_hist  [0:32767];
  logic dout_hist [0:32767];

  always @(negedge clk) begin
    if (pixel_valid === 1'b1) begin
      if (nvalid < 64) begin
        vdata[nvalid] = pixel_data;
        vidx[nvalid]  = pixel_index;
      end
      nvalid++;
    end
    if (frame_done === 1'b1) nfd++;
    if (rx_error === 1'b1) begin
      nerr++;
      ecyc = cyc;
    end
    if (frame_done === 1'b1 && rx_error === 1'b1) nboth++;
    if (dout === 1'b1) ndout++;
    din_hist[cyc[14:0]]  = din;
    dout_hist[cyc[14:0]] = dout;
  end

  task automatic hold(input logic v, input int unsigned n);
    din = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pulse(input int unsigned hi, input int unsigned lo);
    hold(1'b1, hi);
    hold(1'b0, lo);
  endtask

  task automatic send_bit(input logic b);
    if (b) send_pulse(10, 5);
    else   send_pulse(5, 10);
  endtask

  task automatic send_pixel(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    din = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pixel_data !== 24'h0) begin failures++; $display("FAIL reset_pixel_data got=%h exp=000000", pixel_data); end
    checks++; if (pixel_valid !== 1'b0) begin failures++; $display("FAIL reset_pixel_valid got=%b exp=0", pixel_valid); end
    checks++; if (pixel_index !== 8'h0) begin failures++; $display("FAIL reset_pixel_index got=%0d exp=0", pixel_index); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    checks++; if (rx_error !== 1'b0) begin failures++; $display("FAIL reset_rx_error got=%b exp=0", rx_error); end
    checks++; if (dout !== 1'b0) begin failures++; $display("FAIL reset_dout got=%b exp=0", dout); end
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    int bv, bf, be, bd;
    hold(1'b0, 605);
    bv = nvalid; bf = nfd; be = nerr; bd = ndout;
    send_pixel(24'hFF0080);
    hold(1'b0, 620);
    checks++; if (nvalid - bv !== 1) begin failures++; $display("FAIL single_valid_count got=%0d exp=1", nvalid - bv); end
    checks++; if (vdata[bv] !== 24'hFF0080) begin failures++; $display("FAIL single_data got=%h exp=ff0080", vdata[bv]); end
    checks++; if (vidx[bv] !== 8'd0) begin failures++; $display("FAIL single_index got=%0d exp=0", vidx[bv]); end
    checks++; if (nfd - bf !== 1) begin failures++; $display("FAIL single_frame_done got=%0d exp=1", nfd - bf); end
    checks++; if (nerr - be !== 0) begin failures++; $display("FAIL single_rx_error got=%0d exp=0", nerr - be); end
    checks++; if (pixel_data !== 24'hFF0080) begin failures++; $display("FAIL single_data_hold got=%h exp=ff0080", pixel_data); end
`ifndef WS2812B_RX_PASSTHRU_EN
    checks++; if (ndout - bd !== 0) begin failures++; $display("FAIL single_dout_tied got=%0d exp=0", ndout - bd); end
`endif
  endtask

  task automatic test_back_to_back;
    int bv, bf, be;
    logic [23:0] exp_d [0:3];
    logic [7:0]  exp_i [0:3];
    exp_d[0] = 24'h123456; exp_i[0] = 8'd0;
    exp_d[1] = 24'hABCDEF; exp_i[1] = 8'd1;
    exp_d[2] = 24'h000001; exp_i[2] = 8'd2;
    exp_d[3] = 24'h5A5A5A; exp_i[3] = 8'd0;
    bv = nvalid; bf = nfd; be = nerr;
    for (int i = 0; i < 3; i++) send_pixel(exp_d[i]);
    hold(1'b0, 620);
    send_pixel(exp_d[3]);
    hold(1'b0, 620);
    checks++; if (nvalid - bv !== 4) begin failures++; $display("FAIL b2b_valid_count got=%0d exp=4", nvalid - bv); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (vdata[bv+i] !== exp_d[i]) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, vdata[bv+i], exp_d[i]); end
      checks++; if (vidx[bv+i] !== exp_i[i]) begin failures++; $display("FAIL b2b_index[%0d] got=%0d exp=%0d", i, vidx[bv+i], exp_i[i]); end
    end
    checks++; if (nfd - bf !== 2) begin failures++; $display("FAIL b2b_frame_done got=%0d exp=2", nfd - bf); end
    checks++; if (nerr - be !== 0) begin failures++; $display("FAIL b2b_rx_error got=%0d exp=0", nerr - be); end
  endtask

  task automatic test_thresholds;
    int bv, bf, be;
    logic [19:0] tail;
    tail = 20'h5A5A5;
    bv = nvalid; bf = nfd; be = nerr;
    send_pulse(8, 6);   // 1: exactly HIGH_THRESH
    send_pulse(7, 6);   // 0: one below threshold
    send_pulse(2, 6);   // 0: exactly MIN_HIGH, not a glitch
    send_pulse(13, 6);  // 1: one below MAX_HIGH
    for (int i = 19; i >= 0; i--) send_bit(tail[i]);
    hold(1'b0, 620);
    checks++; if (nvalid - bv !== 1) begin failures++; $display("FAIL thresh_valid_count got=%0d exp=1", nvalid - bv); end
    checks++; if (vdata[bv] !== 24'h95A5A5) begin failures++; $display("FAIL thresh_data got=%h exp=95a5a5", vdata[bv]); end
    checks++; if (nerr - be !== 0) begin failures++; $display("FAIL thresh_rx_error got=%0d exp=0", nerr - be); end
    checks++; if (nfd - bf !== 1) begin failures++; $display("FAIL thresh_frame_done got=%0d exp=1", nfd - bf); end
  endtask

  task automatic test_glitch;
    int bv, bf, be;
    logic [23:0] w;
    w = 24'hF0F0F0;
    bv = nvalid; bf = nfd; be = nerr;
    for (int i = 23; i >= 12; i--) send_bit(w[i]);
    send_pulse(1, 14);
    hold(1'b0, 100);
    send_pixel(24'h00FF00);
    hold(1'b0, 620);
    checks++; if (nerr - be !== 1) begin failures++; $display("FAIL glitch_rx_error got=%0d exp=1", nerr - be); end
    checks++; if (nvalid - bv !== 0) begin failures++; $display("FAIL glitch_no_valid got=%0d exp=0", nvalid - bv); end
    checks++; if (nfd - bf !== 0) begin failures++; $display("FAIL glitch_no_frame_done got=%0d exp=0", nfd - bf); end
    bv = nvalid; bf = nfd; be = nerr;
    send_pixel(24'h0F0F0F);
    hold(1'b0, 620);
    checks++; if (nvalid - bv !== 1) begin failures++; $display("FAIL glitch_resync_valid got=%0d exp=1", nvalid - bv); end
    checks++; if (vdata[bv] !== 24'h0F0F0F) begin failures++; $display("FAIL glitch_resync_data got=%h exp=0f0f0f", vdata[bv]); end
    checks++; if (vidx[bv] !== 8'd0) begin failures++; $display("FAIL glitch_resync_index got=%0d exp=0", vidx[bv]); end
    checks++; if (nfd - bf !== 1) begin failures++; $display("FAIL glitch_resync_frame_done got=%0d exp=1", nfd - bf); end
    checks++; if (nerr - be !== 0) begin failures++; $display("FAIL glitch_resync_rx_error got=%0d exp=0", nerr - be); end
  endtask

  task automatic test_errors;
    int bv, bf, be, bb;
    int unsigned c0;
    logic [9:0] part;
    part = 10'h2B3;
    bv = nvalid; bf = nfd; be = nerr;
    c0 = cyc;
    hold(1'b1, 20);
    hold(1'b0, 620);
    checks++; if (nerr - be !== 1) begin failures++; $display("FAIL long_high_rx_error got=%0d exp=1", nerr - be); end
    // 2 sync + 1 edge + 13 counts to reach 14 + 1 output register
    checks++; if (ecyc - c0 !== 17) begin failures++; $display("FAIL long_high_error_delay got=%0d exp=17", ecyc - c0); end
    checks++; if (nvalid - bv !== 0) begin failures++; $display("FAIL long_high_no_valid got=%0d exp=0", nvalid - bv); end
    checks++; if (nfd - bf !== 0) begin failures++; $display("FAIL long_high_no_frame_done got=%0d exp=0", nfd - bf); end
    bv = nvalid; bf = nfd; be = nerr; bb = nboth;
    for (int i = 9; i >= 0; i--) send_bit(part[i]);
    hold(1'b0, 620);
    checks++; if (nfd - bf !== 1) begin failures++; $display("FAIL partial_frame_done got=%0d exp=1", nfd - bf); end
    checks++; if (nerr - be !== 1) begin failures++; $display("FAIL partial_rx_error got=%0d exp=1", nerr - be); end
    checks++; if (nboth - bb !== 1) begin failures++; $display("FAIL partial_same_cycle got=%0d exp=1", nboth - bb); end
    checks++; if (nvalid - bv !== 0) begin failures++; $display("FAIL partial_no_valid got=%0d exp=0", nvalid - bv); end
  endtask

  task automatic test_reset_midframe;
    int bv, bf, be;
    logic [23:0] w;
    w = 24'hABC123;
    for (int i = 23; i >= 13; i--) send_bit(w[i]);
    hold(1'b1, 3);
    rst_n = 1'b0;
    #1;
    checks++; if (pixel_data !== 24'h0) begin failures++; $display("FAIL midrst_pixel_data got=%h exp=000000", pixel_data); end
    checks++; if (pixel_valid !== 1'b0) begin failures++; $display("FAIL midrst_pixel_valid got=%b exp=0", pixel_valid); end
    checks++; if (rx_error !== 1'b0) begin failures++; $display("FAIL midrst_rx_error got=%b exp=0", rx_error); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL midrst_frame_done got=%b exp=0", frame_done); end
    din = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bv = nvalid; bf = nfd; be = nerr;
    send_pixel(24'h111111);
    hold(1'b0, 620);
    checks++; if (nvalid - bv !== 0) begin failures++; $display("FAIL midrst_sync_no_valid got=%0d exp=0", nvalid - bv); end
    checks++; if (nfd - bf !== 0) begin failures++; $display("FAIL midrst_sync_no_frame_done got=%0d exp=0", nfd - bf); end
    bv = nvalid; bf = nfd; be = nerr;
    send_pixel(24'hC3A5F0);
    hold(1'b0, 620);
    checks++; if (nvalid - bv !== 1) begin failures++; $display("FAIL midrst_valid got=%0d exp=1", nvalid - bv); end
    checks++; if (vdata[bv] !== 24'hC3A5F0) begin failures++; $display("FAIL midrst_data got=%h exp=c3a5f0", vdata[bv]); end
    checks++; if (vidx[bv] !== 8'd0) begin failures++; $display("FAIL midrst_index got=%0d exp=0", vidx[bv]); end
    checks++; if (nfd - bf !== 1) begin failures++; $display("FAIL midrst_frame_done got=%0d exp=1", nfd - bf); end
    checks++; if (nerr - be !== 0) begin failures++; $display("FAIL midrst_rx_error got=%0d exp=0", nerr - be); end
  endtask

`ifdef WS2812B_RX_PASSTHRU_EN
  task automatic test_passthru;
    int bv, bad1, bad2, bad3;
    int unsigned cs, c25, ce, cf, cg;
    bv = nvalid;
    cs = cyc;
    send_pixel(24'h00FF00);
    c25 = cyc;
    send_pixel(24'hA5C381);
    ce = cyc;
    hold(1'b0, 620);
    cf = cyc;
    send_pixel(24'hFFFFFF);
    cg = cyc;
    hold(1'b0, 620);
    bad1 = 0; bad2 = 0; bad3 = 0;
    for (int unsigned c = cs; c < c25 + 3; c++) if (dout_hist[c[14:0]] !== 1'b0) bad1++;
    for (int unsigned c = c25 + 3; c < ce + 3; c++) begin
      int unsigned p;
      p = c - 3;
      if (dout_hist[c[14:0]] !== din_hist[p[14:0]]) bad2++;
    end
    for (int unsigned c = cf; c < cg; c++) if (dout_hist[c[14:0]] !== 1'b0) bad3++;
    checks++; if (bad1 !== 0) begin failures++; $display("FAIL pass_first_pixel_blocked bad_cycles=%0d exp=0", bad1); end
    checks++; if (bad2 !== 0) begin failures++; $display("FAIL pass_mirror_delay3 bad_cycles=%0d exp=0", bad2); end
    checks++; if (bad3 !== 0) begin failures++; $display("FAIL pass_closed_after_latch bad_cycles=%0d exp=0", bad3); end
    checks++; if (nvalid - bv !== 3) begin failures++; $display("FAIL pass_valid_count got=%0d exp=3", nvalid - bv); end
  endtask
`endif

  initial begin
    test_reset;
    @(posedge clk);
    #1;
    test_single;
    test_back_to_back;
    test_thresholds;
    test_glitch;
    test_errors;
    test_reset_midframe;
`ifdef WS2812B_RX_PASSTHRU_EN
    test_passthru;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
